// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 Hz VGA raster timing, pixel coordinates and registered RGB/sync.
// Latency: x/y combinational from the counters; rgb/hsync/vsync/frame_tick 1 cycle after the counters.
// Backpressure: none, free-running raster. Optional macro VGA_TEST_PATTERN_EN replaces color with 8 vertical bars.
module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLOCK_25,
    input  logic        reset_active_low,
    input  logic [2:0]  color,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  rgb,
    output logic        frame_tick
);

    // Counter-width constants; every boundary fits in the 10-bit counters.
    localparam logic [9:0] H_VIS_C   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] H_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_VIS_C   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;
    logic [2:0] r_rgb;
    logic       r_frame_tick;
    logic       w_active;
    logic       w_hsync_pulse;
    logic       w_vsync_pulse;

    assign w_active      = (r_h_cnt < H_VIS_C) && (r_v_cnt < V_VIS_C);
    assign w_hsync_pulse = (r_h_cnt >= H_SYNC_LO) && (r_h_cnt < H_SYNC_HI);
    assign w_vsync_pulse = (r_v_cnt >= V_SYNC_LO) && (r_v_cnt < V_SYNC_HI);

    // Coordinates are 1-based inside the active window and 0 anywhere in blanking.
    assign x = w_active ? ({2'b00, r_h_cnt} + 12'd1) : 12'd0;
    assign y = w_active ? ({2'b00, r_v_cnt} + 12'd1) : 12'd0;

    // Raster counters: h wraps every line, v advances only on the h wrap.
    always_ff @(posedge CLOCK_25 or negedge reset_active_low) begin
        if (!reset_active_low) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : (r_v_cnt + 10'd1);
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [6:0] BAR_LAST = 7'(H_VISIBLE / 8 - 1);

    logic [6:0] r_bar_px;
    logic [2:0] r_bar_idx;

    // Bar tracker: r_bar_idx is the bar under the current h_cnt, restarted every line.
    always_ff @(posedge CLOCK_25 or negedge reset_active_low) begin
        if (!reset_active_low) begin
            r_bar_px  <= 7'd0;
            r_bar_idx <= 3'd0;
        end else if (r_h_cnt == H_LAST) begin
            r_bar_px  <= 7'd0;
            r_bar_idx <= 3'd0;
        end else if (r_h_cnt < H_VIS_C) begin
            if (r_bar_px == BAR_LAST) begin
                r_bar_px  <= 7'd0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= r_bar_px + 7'd1;
            end
        end
    end
`endif

    // Pixel and sync outputs registered together so they stay mutually aligned.
    always_ff @(posedge CLOCK_25 or negedge reset_active_low) begin
        if (!reset_active_low) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_rgb        <= 3'b000;
            r_frame_tick <= 1'b0;
        end else begin
            r_hsync      <= !w_hsync_pulse;
            r_vsync      <= !w_vsync_pulse;
`ifdef VGA_TEST_PATTERN_EN
            r_rgb        <= w_active ? r_bar_idx : 3'b000;
`else
            r_rgb        <= w_active ? color : 3'b000;
`endif
            r_frame_tick <= (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS_C);
        end
    end

    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign rgb        = r_rgb;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed vectors against a full-size instance (lines, hsync, rgb, async reset)
// and a short-frame instance (vsync, frame_tick, frame wrap) to keep the run short.
// Outputs are sampled on the falling clock edge; k counts rising edges since reset release.
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst_a;
    logic        rst_b;
    logic [2:0]  color_a;
    logic [2:0]  color_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    logic        hs_a, vs_a, ft_a, hs_b, vs_b, ft_b;
    logic [2:0]  rgb_a, rgb_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #20 clk = ~clk;

    vga_timing dut_a (
        .CLOCK_25(clk), .reset_active_low(rst_a), .color(color_a),
        .x(x_a), .y(y_a), .hsync(hs_a), .vsync(vs_a), .rgb(rgb_a), .frame_tick(ft_a)
    );

    // Short frame: 6 visible lines, vsync on lines 8..9, 13 lines total (10400 cycles).
    vga_timing #(.V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)) dut_b (
        .CLOCK_25(clk), .reset_active_low(rst_b), .color(color_b),
        .x(x_b), .y(y_b), .hsync(hs_b), .vsync(vs_b), .rgb(rgb_b), .frame_tick(ft_b)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int          k;
        logic [11:0] x;
        logic [11:0] y;
        logic        hs;
        logic [2:0]  rgb_col;
        logic [2:0]  rgb_pat;
    } vec_a_t;

    typedef struct {
        int          k;
        logic [11:0] x;
        logic [11:0] y;
        logic        vs;
        logic        ft;
    } vec_b_t;

    vec_a_t va[16];
    vec_b_t vb[13];

`ifdef VGA_TEST_PATTERN_EN
    localparam int RUN_LEN = 560;
    localparam logic [2:0] MID_RGB = 3'b011;
`else
    localparam int RUN_LEN = 640;
    localparam logic [2:0] MID_RGB = 3'b101;
`endif

    initial begin
        int ia, ib, xe;
        int hs_low, n_falls, last_fall, bad_space, run, n_runs, bad_run, xbad;
        int vs_low, v_falls, v_last, v_bad_space, v_run, v_bad_run;
        int ticks, t_last, t_bad_space, rgb_cnt;
        logic prev_hs, prev_vs;

        // k, x, y, hsync, rgb (color=101), rgb (bar pattern)
        va[0]  = '{0,    12'd1,   12'd1, 1'b1, 3'b000, 3'b000};
        va[1]  = '{1,    12'd2,   12'd1, 1'b1, 3'b101, 3'b000};
        va[2]  = '{80,   12'd81,  12'd1, 1'b1, 3'b101, 3'b000};
        va[3]  = '{81,   12'd82,  12'd1, 1'b1, 3'b101, 3'b001};
        va[4]  = '{639,  12'd640, 12'd1, 1'b1, 3'b101, 3'b111};
        va[5]  = '{640,  12'd0,   12'd0, 1'b1, 3'b101, 3'b111};
        va[6]  = '{641,  12'd0,   12'd0, 1'b1, 3'b000, 3'b000};
        va[7]  = '{656,  12'd0,   12'd0, 1'b1, 3'b000, 3'b000};
        va[8]  = '{657,  12'd0,   12'd0, 1'b0, 3'b000, 3'b000};
        va[9]  = '{752,  12'd0,   12'd0, 1'b0, 3'b000, 3'b000};
        va[10] = '{753,  12'd0,   12'd0, 1'b1, 3'b000, 3'b000};
        va[11] = '{799,  12'd0,   12'd0, 1'b1, 3'b000, 3'b000};
        va[12] = '{800,  12'd1,   12'd2, 1'b1, 3'b000, 3'b000};
        va[13] = '{801,  12'd2,   12'd2, 1'b1, 3'b101, 3'b000};
        va[14] = '{1440, 12'd0,   12'd0, 1'b1, 3'b101, 3'b111};
        va[15] = '{1441, 12'd0,   12'd0, 1'b1, 3'b000, 3'b000};

        // k, x, y, vsync, frame_tick for the short-frame instance
        vb[0]  = '{0,     12'd1, 12'd1, 1'b1, 1'b0};
        vb[1]  = '{4000,  12'd1, 12'd6, 1'b1, 1'b0};
        vb[2]  = '{4799,  12'd0, 12'd0, 1'b1, 1'b0};
        vb[3]  = '{4800,  12'd0, 12'd0, 1'b1, 1'b0};
        vb[4]  = '{4801,  12'd0, 12'd0, 1'b1, 1'b1};
        vb[5]  = '{4802,  12'd0, 12'd0, 1'b1, 1'b0};
        vb[6]  = '{6400,  12'd0, 12'd0, 1'b1, 1'b0};
        vb[7]  = '{6401,  12'd0, 12'd0, 1'b0, 1'b0};
        vb[8]  = '{8000,  12'd0, 12'd0, 1'b0, 1'b0};
        vb[9]  = '{8001,  12'd0, 12'd0, 1'b1, 1'b0};
        vb[10] = '{10399, 12'd0, 12'd0, 1'b1, 1'b0};
        vb[11] = '{10400, 12'd1, 12'd1, 1'b1, 1'b0};
        vb[12] = '{10401, 12'd2, 12'd1, 1'b1, 1'b0};

        color_a = 3'b101;
        color_b = 3'b101;
        rst_a   = 1'b0;
        rst_b   = 1'b0;

        // Reset held: registered outputs at reset values, coordinates at (1,1).
        repeat (3) @(negedge clk);
        chk("rst_hsync", int'(hs_a), 1);
        chk("rst_vsync", int'(vs_a), 1);
        chk("rst_rgb",   int'(rgb_a), 0);
        chk("rst_ftick", int'(ft_a), 0);
        chk("rst_x",     int'(x_a), 1);
        chk("rst_y",     int'(y_a), 1);

        // Full-size instance: three lines of vectors plus per-cycle line metrics.
        rst_a = 1'b1;
        #1;
        ia = 0; hs_low = 0; n_falls = 0; last_fall = -1; bad_space = 0;
        run = 0; n_runs = 0; bad_run = 0; xbad = 0; prev_hs = 1'b1;
        for (int k = 0; k <= 2400; k++) begin
            if (k > 0) @(negedge clk);
            if (ia < 16 && va[ia].k == k) begin
                chk($sformatf("a_x@%0d", k),  int'(x_a),  int'(va[ia].x));
                chk($sformatf("a_y@%0d", k),  int'(y_a),  int'(va[ia].y));
                chk($sformatf("a_hs@%0d", k), int'(hs_a), int'(va[ia].hs));
`ifdef VGA_TEST_PATTERN_EN
                chk($sformatf("a_rgb@%0d", k), int'(rgb_a), int'(va[ia].rgb_pat));
`else
                chk($sformatf("a_rgb@%0d", k), int'(rgb_a), int'(va[ia].rgb_col));
`endif
                ia++;
            end
            xe = ((k % 800) < 640) ? (k % 800) + 1 : 0;
            if (int'(x_a) != xe) xbad++;
            if (k > 0) begin
                if (!hs_a) hs_low++;
                if (prev_hs && !hs_a) begin
                    if (last_fall >= 0 && (k - last_fall) != 800) bad_space++;
                    last_fall = k;
                    n_falls++;
                end
                prev_hs = hs_a;
                if (rgb_a != 3'b000) run++;
                else if (run > 0) begin
                    if (run != RUN_LEN) bad_run++;
                    n_runs++;
                    run = 0;
                end
            end
        end
        chk("vec_a_all_applied", ia, 16);
        chk("x_model_errors",    xbad, 0);
        chk("hsync_low_cycles",  hs_low, 288);
        chk("hsync_falls",       n_falls, 3);
        chk("hsync_fall_period", bad_space, 0);
        chk("rgb_runs",          n_runs, 3);
        chk("rgb_run_length",    bad_run, 0);

        // Mid-line async reset at h_cnt=300 on line 3.
        repeat (300) @(negedge clk);
        chk("pre_rst_x",   int'(x_a),   301);
        chk("pre_rst_rgb", int'(rgb_a), int'(MID_RGB));
        #5 rst_a = 1'b0;
        #1;
        chk("async_rst_rgb",   int'(rgb_a), 0);
        chk("async_rst_hsync", int'(hs_a),  1);
        chk("async_rst_vsync", int'(vs_a),  1);
        chk("async_rst_ftick", int'(ft_a),  0);
        chk("async_rst_x",     int'(x_a),   1);
        chk("async_rst_y",     int'(y_a),   1);
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        chk("restart_x0", int'(x_a), 1);
        chk("restart_y0", int'(y_a), 1);
        @(negedge clk);
        chk("restart_x1", int'(x_a), 2);
        chk("restart_y1", int'(y_a), 1);
`ifdef VGA_TEST_PATTERN_EN
        chk("restart_rgb", int'(rgb_a), 0);
`else
        chk("restart_rgb", int'(rgb_a), 5);
`endif

        // Short-frame instance: two frames of vsync/frame_tick behaviour.
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        ib = 0; vs_low = 0; v_falls = 0; v_last = -1; v_bad_space = 0;
        v_run = 0; v_bad_run = 0; ticks = 0; t_last = -1; t_bad_space = 0;
        rgb_cnt = 0; prev_vs = 1'b1;
        for (int k = 0; k <= 20810; k++) begin
            if (k > 0) @(negedge clk);
            if (ib < 13 && vb[ib].k == k) begin
                chk($sformatf("b_x@%0d", k),  int'(x_b),  int'(vb[ib].x));
                chk($sformatf("b_y@%0d", k),  int'(y_b),  int'(vb[ib].y));
                chk($sformatf("b_vs@%0d", k), int'(vs_b), int'(vb[ib].vs));
                chk($sformatf("b_ft@%0d", k), int'(ft_b), int'(vb[ib].ft));
                ib++;
            end
            if (k > 0) begin
                if (k <= 10400 && rgb_b != 3'b000) rgb_cnt++;
                if (!vs_b) begin
                    vs_low++;
                    v_run++;
                end else if (v_run > 0) begin
                    if (v_run != 1600) v_bad_run++;
                    v_run = 0;
                end
                if (prev_vs && !vs_b) begin
                    if (v_last >= 0 && (k - v_last) != 10400) v_bad_space++;
                    v_last = k;
                    v_falls++;
                end
                prev_vs = vs_b;
                if (ft_b) begin
                    if (t_last >= 0 && (k - t_last) != 10400) t_bad_space++;
                    t_last = k;
                    ticks++;
                end
            end
        end
        chk("vec_b_all_applied",  ib, 13);
        chk("vsync_low_cycles",   vs_low, 3200);
        chk("vsync_run_length",   v_bad_run, 0);
        chk("vsync_falls",        v_falls, 2);
        chk("vsync_fall_period",  v_bad_space, 0);
        chk("ftick_count",        ticks, 2);
        chk("ftick_period",       t_bad_space, 0);
        chk("frame_rgb_cycles",   rgb_cnt, 6 * RUN_LEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
